// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
package seq_det_pkg;

    // Legal parameter ranges, checked at elaboration by the top level
    localparam int unsigned PAT_W_MIN   = 2;
    localparam int unsigned PAT_W_MAX   = 32;
    localparam int unsigned COUNT_W_MIN = 1;
    localparam int unsigned COUNT_W_MAX = 32;

    // Detector state encoding
    typedef logic [1:0] state_t;

    localparam state_t UNARMED = 2'd0;
    localparam state_t FILLING = 2'd1;
    localparam state_t ARMED   = 2'd2;

endpackage

// File: rtl/seq_shift_reg.sv
// Serial history register with a saturating fill counter.
// Newest bit enters at the LSB; clear takes priority over shift.
module seq_shift_reg #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned FILL_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              clr,
    input  logic              x,
    output logic [WIDTH-1:0]  hist,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);

    logic [WIDTH-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Next history and fill: clear wins, otherwise shift and count up to WIDTH
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = {hist_q[WIDTH-2:0], x};
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // History and fill state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with loadable pattern, input
// qualifier, overlap selection and saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W   = 4,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x,
    input  logic               x_valid,
    input  logic               load_pat,
    input  logic [PAT_W-1:0]   pat_in,
    input  logic               overlap_en,
    input  logic               clr_cnt,
    output logic               z,
    output logic [COUNT_W-1:0] match_cnt,
    output logic               cnt_sat,
    output logic               armed
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

    // Reject out-of-range parameters at elaboration
    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W out of legal range");
    end
    if (COUNT_W < COUNT_W_MIN || COUNT_W > COUNT_W_MAX) begin : g_bad_count_w
        $error("seq_detector_param: COUNT_W out of legal range");
    end

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               z_q, sat_q;

    logic [PAT_W-1:0]   hist;
    logic [FILL_W-1:0]  fill;
    logic [PAT_W-1:0]   cand;
    logic               accept;
    logic               last_fill;
    logic               eval;
    logic               match;
    logic               shift_clr;
    logic               unused_hist_msb;

    // Oldest history bit falls off when the candidate is formed
    assign unused_hist_msb = hist[PAT_W-1];

    // A bit is taken only when armed for input and no pattern load is pending
    assign accept    = x_valid && !load_pat && (state_q != UNARMED);
    assign last_fill = (state_q == FILLING) && (fill == FILL_LAST);
    assign eval      = accept && ((state_q == ARMED) || last_fill);
    assign cand      = {hist[PAT_W-2:0], x};
    assign match     = eval && (cand == pat_q);

    // Non-overlapping matches restart collection from an empty history
    assign shift_clr = load_pat || (match && !overlap_en);

    seq_shift_reg #(
        .WIDTH  (PAT_W),
        .FILL_W (FILL_W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .clr      (shift_clr),
        .x        (x),
        .hist     (hist),
        .fill     (fill)
    );

    // Next state: load restarts filling; a non-overlap match returns to filling
    always_comb begin
        state_d = state_q;
        if (load_pat) begin
            state_d = FILLING;
        end else if (accept) begin
            case (state_q)
                FILLING: begin
                    if (last_fill) begin
                        state_d = (match && !overlap_en) ? FILLING : ARMED;
                    end
                end
                ARMED: begin
                    if (match && !overlap_en) begin
                        state_d = FILLING;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Pattern capture
    always_comb begin
        pat_d = pat_q;
        if (load_pat) begin
            pat_d = pat_in;
        end
    end

    // Saturating match counter; a clear coinciding with a match leaves one
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = match ? COUNT_W'(1) : '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    // FSM, pattern, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNARMED;
            pat_q   <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            z_q     <= match;
            sat_q   <= (cnt_d == CNT_MAX);
        end
    end

    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
    assign armed     = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PAT_W=4, COUNT_W=2).
module tb_seq_detector_param;
    import seq_det_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x;
    logic       x_valid;
    logic       load_pat;
    logic [3:0] pat_in;
    logic       overlap_en;
    logic       clr_cnt;
    logic       z;
    logic [1:0] match_cnt;
    logic       cnt_sat;
    logic       armed;

    int n_cmp;
    int n_err;

    seq_detector_param #(
        .PAT_W   (4),
        .COUNT_W (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .x_valid    (x_valid),
        .load_pat   (load_pat),
        .pat_in     (pat_in),
        .overlap_en (overlap_en),
        .clr_cnt    (clr_cnt),
        .z          (z),
        .match_cnt  (match_cnt),
        .cnt_sat    (cnt_sat),
        .armed      (armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one bit, then sample 1 time unit after the edge
    task automatic step(input logic xb, input logic v);
        x       = xb;
        x_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] p, input logic clr);
        load_pat = 1'b1;
        pat_in   = p;
        clr_cnt  = clr;
        x_valid  = 1'b0;
        @(posedge clk);
        #1;
        load_pat = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    initial begin
        logic [6:0] s;
        logic [6:0] ez;
        int         ec;

        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b1;
        x          = 1'b0;
        x_valid    = 1'b0;
        load_pat   = 1'b0;
        pat_in     = 4'b0000;
        overlap_en = 1'b1;
        clr_cnt    = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_z", z, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_sat", cnt_sat, 0);
        chk("rst_armed", armed, 0);
        chk("rst_state", dut.state_q, UNARMED);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // UNARMED ignores valid data
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            chk("ign_z", z, 0);
            chk("ign_cnt", match_cnt, 0);
            chk("ign_armed", armed, 0);
        end

        // Single match on 1011
        do_load(4'b1011, 1'b0);
        chk("load_state", dut.state_q, FILLING);
        step(1'b1, 1'b1); chk("s1_z", z, 0); chk("s1_armed", armed, 0);
        step(1'b0, 1'b1); chk("s2_z", z, 0); chk("s2_armed", armed, 0);
        step(1'b1, 1'b1); chk("s3_z", z, 0); chk("s3_armed", armed, 0);
        step(1'b1, 1'b1);
        chk("s4_z", z, 1);
        chk("s4_armed", armed, 1);
        chk("s4_cnt", match_cnt, 1);
        chk("s4_sat", cnt_sat, 0);
        step(1'b0, 1'b0);
        chk("s5_z", z, 0);
        chk("s5_cnt", match_cnt, 1);

        // Overlapping stream 1011011
        overlap_en = 1'b1;
        do_load(4'b1011, 1'b1);
        chk("ov_clr_cnt", match_cnt, 0);
        s  = 7'b1011011;
        ez = 7'b0001001;
        for (int i = 0; i < 7; i++) begin
            step(s[6-i], 1'b1);
            chk("ov_z", z, ez[6-i]);
        end
        chk("ov_cnt", match_cnt, 2);

        // Non-overlapping stream 1011011
        overlap_en = 1'b0;
        do_load(4'b1011, 1'b1);
        ez = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            step(s[6-i], 1'b1);
            chk("nov_z", z, ez[6-i]);
        end
        chk("nov_cnt", match_cnt, 1);
        chk("nov_armed", armed, 0);
        chk("nov_state", dut.state_q, FILLING);
        chk("nov_fill", dut.fill, 3);

        // Valid gaps: x=1 while x_valid=0 must not shift in
        overlap_en = 1'b1;
        do_load(4'b1011, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("gap_z", z, 0);
        end
        step(1'b1, 1'b1);
        chk("gap_pre_z", z, 0);
        step(1'b1, 1'b1);
        chk("gap_z_last", z, 1);
        chk("gap_cnt", match_cnt, 1);

        // Saturation with pattern 1111
        do_load(4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            ec = (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2);
            chk("sat_z", z, (i >= 3) ? 1 : 0);
            chk("sat_cnt", match_cnt, ec);
            chk("sat_flag", cnt_sat, (i >= 5) ? 1 : 0);
        end
        clr_cnt = 1'b1;
        step(1'b1, 1'b1);
        clr_cnt = 1'b0;
        chk("clrm_z", z, 1);
        chk("clrm_cnt", match_cnt, 1);
        chk("clrm_sat", cnt_sat, 0);
        clr_cnt = 1'b1;
        step(1'b0, 1'b0);
        clr_cnt = 1'b0;
        chk("clr_cnt", match_cnt, 0);
        chk("clr_z", z, 0);

        // load_pat wins over a coincident valid bit (history 1111 would match)
        load_pat = 1'b1;
        pat_in   = 4'b1111;
        step(1'b1, 1'b1);
        load_pat = 1'b0;
        chk("ldv_z", z, 0);
        chk("ldv_fill", dut.fill, 0);
        chk("ldv_state", dut.state_q, FILLING);
        chk("ldv_cnt", match_cnt, 0);

        // Asynchronous reset mid-stream, straight after a match
        do_load(4'b1011, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("ar_pre_z", z, 1);
        chk("ar_pre_cnt", match_cnt, 1);
        x_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_z", z, 0);
        chk("ar_cnt", match_cnt, 0);
        chk("ar_sat", cnt_sat, 0);
        chk("ar_armed", armed, 0);
        chk("ar_state", dut.state_q, UNARMED);
        chk("ar_pat", dut.pat_q, 0);
        #1 rst_n = 1'b1;
        s = 7'b0001011;
        for (int i = 0; i < 4; i++) begin
            step(s[3-i], 1'b1);
            chk("post_z", z, 0);
            chk("post_armed", armed, 0);
        end
        chk("post_cnt", match_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
